// File: rtl/framebuffer_rect_writer_if.sv
// rtl/framebuffer_rect_writer_if.sv - command handshake and frame buffer write port bundle
interface framebuffer_rect_writer_if #(
    parameter int ADDR_W  = 19,
    parameter int COLOR_W = 2
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_clear;
    logic [9:0]         cmd_x;
    logic [8:0]         cmd_y;
    logic [9:0]         cmd_w;
    logic [8:0]         cmd_h;
    logic [COLOR_W-1:0] cmd_color;
    logic               done;
    logic [ADDR_W-1:0]  write_addr;
    logic [23:0]        write_data;
    logic               write_en;

    modport master (
        output cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        input  cmd_ready, done, write_addr, write_data, write_en
    );

    modport slave (
        input  cmd_valid, cmd_clear, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        output cmd_ready, done, write_addr, write_data, write_en
    );
endinterface

// File: rtl/framebuffer_rect_writer.sv
// rtl/framebuffer_rect_writer.sv - clipped rectangle fill / clear engine for the overlay frame buffer
module framebuffer_rect_writer #(
    parameter int FB_WIDTH  = 640,
    parameter int FB_HEIGHT = 480,
    parameter int ADDR_W    = 19,
    parameter int COLOR_W   = 2
) (
    input  logic                       write_clk_i,
    input  logic                       rst_n_i,
    framebuffer_rect_writer_if.slave   bus
);
    localparam int DATA_W = 24;

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_FINISH} state_t;

    state_t              state_q;
    logic [9:0]          x_start_q;
    logic [9:0]          cur_x_q;
    logic [8:0]          cur_y_q;
    logic [10:0]         x_end_q;
    logic [10:0]         y_end_q;
    logic [ADDR_W-1:0]   row_base_q;
    logic                cmd_ready_q;
    logic                done_q;
    logic [ADDR_W-1:0]   write_addr_q;
    logic [DATA_W-1:0]   write_data_q;
    logic                write_en_q;

    logic [9:0]          x_eff_d;
    logic [8:0]          y_eff_d;
    logic [10:0]         x_sum_d;
    logic [10:0]         y_sum_d;
    logic [10:0]         x_end_d;
    logic [10:0]         y_end_d;
    logic [COLOR_W-1:0]  color_d;
    logic                empty_d;
    logic                accept_d;
    logic [ADDR_W-1:0]   y_base_d;
    logic [ADDR_W-1:0]   next_row_base_d;
    logic                x_last_d;
    logic                y_last_d;

    always_comb begin
        x_eff_d  = bus.cmd_clear ? 10'd0 : bus.cmd_x;
        y_eff_d  = bus.cmd_clear ? 9'd0  : bus.cmd_y;
        color_d  = bus.cmd_clear ? '0    : bus.cmd_color;
        x_sum_d  = {1'b0, bus.cmd_x} + {1'b0, bus.cmd_w};
        y_sum_d  = {2'b0, bus.cmd_y} + {2'b0, bus.cmd_h};
        x_end_d  = (bus.cmd_clear || x_sum_d > 11'(FB_WIDTH))  ? 11'(FB_WIDTH)  : x_sum_d;
        y_end_d  = (bus.cmd_clear || y_sum_d > 11'(FB_HEIGHT)) ? 11'(FB_HEIGHT) : y_sum_d;
        empty_d  = !bus.cmd_clear &&
                   (bus.cmd_w == 10'd0 || bus.cmd_h == 9'd0 ||
                    {1'b0, bus.cmd_x} >= 11'(FB_WIDTH) ||
                    {2'b0, bus.cmd_y} >= 11'(FB_HEIGHT));
        accept_d = bus.cmd_valid && cmd_ready_q;
        // y*640 as y*512 + y*128 keeps the row base multiplier-free
        y_base_d = (ADDR_W'(y_eff_d) << 9) + (ADDR_W'(y_eff_d) << 7);
        next_row_base_d = row_base_q + ADDR_W'(FB_WIDTH);
        x_last_d = ({1'b0, cur_x_q} + 11'd1) == x_end_q;
        y_last_d = ({2'b0, cur_y_q} + 11'd1) == y_end_q;
    end

    always_ff @(posedge write_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= S_IDLE;
            x_start_q    <= '0;
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            x_end_q      <= '0;
            y_end_q      <= '0;
            row_base_q   <= '0;
            cmd_ready_q  <= 1'b1;
            done_q       <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            write_en_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        x_start_q   <= x_eff_d;
                        cur_x_q     <= x_eff_d;
                        cur_y_q     <= y_eff_d;
                        x_end_q     <= x_end_d;
                        y_end_q     <= y_end_d;
                        row_base_q  <= y_base_d;
                        cmd_ready_q <= 1'b0;
                        if (empty_d) begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            // first pixel is presented straight out of the accept edge
                            state_q      <= S_FILL;
                            write_en_q   <= 1'b1;
                            write_addr_q <= y_base_d + ADDR_W'(x_eff_d);
                            write_data_q <= {{(DATA_W-COLOR_W){1'b0}}, color_d};
                        end
                    end
                end
                S_FILL: begin
                    if (x_last_d && y_last_d) begin
                        // address/data stay put: the RAM enable is tied high
                        state_q    <= S_FINISH;
                        write_en_q <= 1'b0;
                        done_q     <= 1'b1;
                    end else if (x_last_d) begin
                        cur_x_q      <= x_start_q;
                        cur_y_q      <= cur_y_q + 9'd1;
                        row_base_q   <= next_row_base_d;
                        write_addr_q <= next_row_base_d + ADDR_W'(x_start_q);
                    end else begin
                        cur_x_q      <= cur_x_q + 10'd1;
                        write_addr_q <= write_addr_q + ADDR_W'(1);
                    end
                end
                S_FINISH: begin
                    state_q     <= S_IDLE;
                    done_q      <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= S_IDLE;
                    done_q      <= 1'b0;
                    write_en_q  <= 1'b0;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.done       = done_q;
    assign bus.write_addr = write_addr_q;
    assign bus.write_data = write_data_q;
    assign bus.write_en   = write_en_q;
endmodule

// File: tb/tb_framebuffer_rect_writer.sv
// tb/tb_framebuffer_rect_writer.sv - directed bench for framebuffer_rect_writer
module tb_framebuffer_rect_writer;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_bad;

    framebuffer_rect_writer_if #(.ADDR_W(19), .COLOR_W(2)) bus ();

    framebuffer_rect_writer #(
        .FB_WIDTH(640), .FB_HEIGHT(480), .ADDR_W(19), .COLOR_W(2)
    ) dut (
        .write_clk_i (clk),
        .rst_n_i     (rst_n),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive_cmd(input logic clr, input int x, input int y, input int w,
                             input int h, input int c);
        bus.cmd_clear = clr;
        bus.cmd_x     = 10'(x);
        bus.cmd_y     = 9'(y);
        bus.cmd_w     = 10'(w);
        bus.cmd_h     = 9'(h);
        bus.cmd_color = 2'(c);
    endtask

    task automatic send(input string tag, input logic clr, input int x, input int y,
                        input int w, input int h, input int c);
        @(negedge clk);
        check({tag, "_ready"}, 32'(bus.cmd_ready), 32'd1);
        drive_cmd(clr, x, y, w, h, c);
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic expect_write(input string tag, input int a, input int d);
        @(negedge clk);
        check({tag, "_en"},   32'(bus.write_en),   32'd1);
        check({tag, "_addr"}, 32'(bus.write_addr), 32'(a));
        check({tag, "_data"}, bus.write_data,      32'(d));
    endtask

    task automatic expect_done(input string tag);
        @(negedge clk);
        check({tag, "_done"},    32'(bus.done),      32'd1);
        check({tag, "_en_off"},  32'(bus.write_en),  32'd0);
        check({tag, "_busy"},    32'(bus.cmd_ready), 32'd0);
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        check({tag, "_idle_rdy"},  32'(bus.cmd_ready), 32'd1);
        check({tag, "_idle_done"}, 32'(bus.done),      32'd0);
        check({tag, "_idle_en"},   32'(bus.write_en),  32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_bad = 0;
        clk   = 1'b0;
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        drive_cmd(1'b0, 0, 0, 0, 0, 0);

        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.cmd_ready),  32'd1);
        check("rst_en",    32'(bus.write_en),   32'd0);
        check("rst_addr",  32'(bus.write_addr), 32'd0);
        check("rst_done",  32'(bus.done),       32'd0);
        rst_n = 1'b1;
        expect_idle("post_rst");
        check("post_rst_addr", 32'(bus.write_addr), 32'd0);

        // 3x2 rectangle at (10,2)
        send("rect", 1'b0, 10, 2, 3, 2, 3);
        expect_write("rect0", 1290, 3);
        expect_write("rect1", 1291, 3);
        expect_write("rect2", 1292, 3);
        expect_write("rect3", 1930, 3);
        expect_write("rect4", 1931, 3);
        expect_write("rect5", 1932, 3);
        expect_done("rect");
        expect_idle("rect");
        check("rect_hold_addr", 32'(bus.write_addr), 32'd1932);
        check("rect_hold_data", bus.write_data,      32'd3);

        // bottom-right corner clipping
        send("clip", 1'b0, 638, 479, 5, 4, 1);
        expect_write("clip0", 307198, 1);
        expect_write("clip1", 307199, 1);
        expect_done("clip");
        expect_idle("clip");
        check("clip_hold_addr", 32'(bus.write_addr), 32'd307199);

        // degenerate commands
        send("w0", 1'b0, 5, 5, 0, 3, 2);
        expect_done("w0");
        expect_idle("w0");
        check("w0_hold_addr", 32'(bus.write_addr), 32'd307199);
        send("x700", 1'b0, 700, 5, 4, 3, 2);
        expect_done("x700");
        expect_idle("x700");
        check("x700_hold_data", bus.write_data, 32'd1);

        // busy: second command held on valid during the first fill
        @(negedge clk);
        check("busy_ready", 32'(bus.cmd_ready), 32'd1);
        drive_cmd(1'b0, 0, 0, 2, 1, 2);
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        check("busyA0_en",   32'(bus.write_en),   32'd1);
        check("busyA0_addr", 32'(bus.write_addr), 32'd0);
        check("busyA0_data", bus.write_data,      32'd2);
        drive_cmd(1'b0, 4, 1, 1, 1, 1);
        expect_write("busyA1", 1, 2);
        expect_done("busyA");
        @(negedge clk);
        check("busyB_ready", 32'(bus.cmd_ready), 32'd1);
        check("busyB_en",    32'(bus.write_en),  32'd0);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        expect_write("busyB0", 644, 1);
        expect_done("busyB");
        expect_idle("busyB");

        // clear: opening rows including the first row wrap, then abort
        send("clr", 1'b1, 5, 5, 7, 7, 3);
        for (int i = 0; i < 1300; i++) begin
            expect_write($sformatf("clr%0d", i), i, 0);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("clr_abort_addr", 32'(bus.write_addr), 32'd0);
        check("clr_abort_en",   32'(bus.write_en),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_idle("clr_abort");

        // reset during the 4th write of a 3x3 fill
        send("rf", 1'b0, 1, 1, 3, 3, 2);
        expect_write("rf0", 641, 2);
        expect_write("rf1", 642, 2);
        expect_write("rf2", 643, 2);
        expect_write("rf3", 1281, 2);
        #2 rst_n = 1'b0;
        #1;
        check("rf_async_en",    32'(bus.write_en),   32'd0);
        check("rf_async_addr",  32'(bus.write_addr), 32'd0);
        check("rf_async_data",  bus.write_data,      32'd0);
        check("rf_async_ready", 32'(bus.cmd_ready),  32'd1);
        check("rf_async_done",  32'(bus.done),       32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check($sformatf("rf_hold_done%0d", i), 32'(bus.done), 32'd0);
        end
        rst_n = 1'b1;
        expect_idle("rf_release");
        expect_idle("rf_release2");
        check("rf_release_addr", 32'(bus.write_addr), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/framebuffer_rect_writer.md
# framebuffer_rect_writer

Write-side drawing engine for the 640x480 overlay frame buffer: accepts rectangle-fill and clear-screen commands over a valid/ready handshake and streams one pixel write per clock into the buffer's write port (address, data, clock domain). Sits between game logic (paddles, ball, score) and the frame buffer RAM. The VGA read side then overlays non-zero pixels on the video stream. Rectangles are clipped to the visible area, and pixel addresses are generated incrementally without a multiplier.

## Interface
- FB_WIDTH, 640, visible pixels per line; also the row stride in addresses.
- FB_HEIGHT, 480, visible lines.
- ADDR_W, 19, write address width.
- COLOR_W, 2, meaningful pixel bits; 0 = transparent.
- WRITE_CLK  in  1  single clock, same as the frame buffer write clock.
- RST_N  in  1  reset, asynchronous, active-low.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  engine idle, command accepted when VALID && READY.
- CMD_CLEAR  in  1  1 = clear whole buffer to color 0; X/Y/W/H/COLOR ignored.
- CMD_X  in  10  left column.
- CMD_Y  in  9  top line.
- CMD_W  in  10  width in pixels.
- CMD_H  in  9  height in lines.
- CMD_COLOR  in  COLOR_W  fill value.
- DONE  out  1  one-cycle pulse after the last write of a command.
- WRITE_ADDR  out  ADDR_W  pixel address, y*FB_WIDTH + x.
- WRITE_DATA  out  24  {22'b0, color}.
- WRITE_EN  out  1  high on cycles carrying a new pixel write.

## Operation
- States are IDLE, FILL and FINISH.
- In IDLE:
  - CMD_READY = 1.
  - On acceptance, latch the command and compute the clipped bounds:
    - x_end = min(X+W, FB_WIDTH) and y_end = min(Y+H, FB_HEIGHT), using 11-bit sums.
    - CLEAR substitutes X=0, Y=0, x_end=640, y_end=480, color=0.
  - If W==0, H==0, X>=FB_WIDTH or Y>=FB_HEIGHT: go to FINISH with no writes.
  - Otherwise go to FILL with cur_x=X, cur_y=Y, row_base=Y*FB_WIDTH. row_base is formed as (Y<<9)+(Y<<7), a shift-add with no multiplier.
- In FILL, each cycle:
  - Emit WRITE_ADDR=row_base+cur_x, WRITE_DATA=color, WRITE_EN=1.
  - cur_x increments. When cur_x+1==x_end: cur_x returns to X, cur_y increments and row_base += FB_WIDTH.
  - After the write at (x_end-1, y_end-1), go to FINISH.
- FINISH lasts one cycle: DONE=1, CMD_READY=0. The next state is IDLE.
- CMD_READY is 0 in FILL and FINISH; CMD_VALID in those states is ignored and not queued.
- Idle hold rule: the frame buffer write enable is tied high. Outside FILL, WRITE_ADDR and WRITE_DATA therefore hold the last values written, so repeated writes are idempotent; WRITE_EN=0.
- Reset values:
  - State is IDLE; CMD_READY=1, DONE=0.
  - WRITE_ADDR=0, WRITE_DATA=0, WRITE_EN=0.
- RST_N asserted mid-FILL aborts immediately: partial rectangle left in memory, no DONE.

## Timing
- All outputs are registered.
- Acceptance at edge N gives the first write presented in cycle N+1.
- A rectangle of clipped size w x h occupies w*h consecutive FILL cycles with no bubbles, including across row wraps.
- DONE is high in the cycle after the last write. CMD_READY is 1 the cycle after DONE, so back-to-back commands are spaced by w*h+2 cycles.
- A degenerate or off-screen command gives DONE in cycle N+1 and READY in cycle N+2.
- CLEAR takes exactly 307200 write cycles; addresses run 0..307199 in order.
- Address arithmetic is ADDR_W bits wide. The maximum address 307199 fits, and no wrap can occur after clipping.

## Test plan
- Reset, then idle:
  - Required: CMD_READY=1, WRITE_EN=0, WRITE_ADDR=0, DONE=0.
  - Then X=10, Y=2, W=3, H=2, COLOR=3 → writes to 1290, 1291, 1292, 1930, 1931, 1932, all with data 3, on 6 consecutive cycles, then a one-cycle DONE.
- Clipping: X=638, Y=479, W=5, H=4, COLOR=1 → exactly 2 writes, to 307198 and 307199, then DONE.
- Degenerate: W=0, and separately X=700 → zero WRITE_EN cycles and DONE one cycle after acceptance.
- CLEAR:
  - Required: 307200 writes, addresses 0..307199 in order, data 0, then DONE.
  - Afterwards WRITE_ADDR holds 307199 with WRITE_EN=0.
- Busy handling: CMD_VALID held high with a second command during a fill → second command accepted only on the cycle after DONE; its first write appears at the following cycle.
- Reset mid-fill: RST_N low during the 4th write of a 3x3 fill → outputs take reset values asynchronously, no DONE, and CMD_READY=1 after release.
